// File: rtl/spi_flash_pkg.sv
// Shared opcodes, frame field lengths and FSM state encoding for the SPI NOR flash model.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_flash_mem.sv
// Word-wide flash array: synchronous preload write, asynchronous byte read by byte address.
module spi_flash_mem #(
  parameter int FLASH_AW = 22
) (
  input  logic                clock,
  input  logic                ld_valid,
  input  logic [FLASH_AW-1:0] ld_addr,
  input  logic [31:0]         ld_data,
  input  logic [FLASH_AW+1:0] rd_byte_addr,
  output logic [7:0]          rd_byte
);

  logic [31:0] mem [2**FLASH_AW];
  logic [31:0] rd_word;
  logic [31:0] rd_shifted;

  // Contents are deliberately not reset; the preload port is the only initialisation path.
  always_ff @(posedge clock) begin
    if (ld_valid) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign rd_word    = mem[rd_byte_addr[FLASH_AW+1:2]];
  assign rd_shifted = rd_word >> {rd_byte_addr[1:0], 3'b000};
  assign rd_byte    = rd_shifted[7:0];

endmodule

// File: rtl/spi_flash_model.sv
// SPI mode-0 NOR flash slave answering READ (0x03) from a preloadable array.
// Optional SPI_FLASH_FAST_READ_EN adds FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_model
  import spi_flash_pkg::*;
#(
  parameter int FLASH_AW = 22,
  parameter int SS_IDX   = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                spi_sck,
  input  logic                spi_ss,
  input  logic                spi_mosi,
  output logic                spi_miso,
  input  logic                ld_valid,
  input  logic [FLASH_AW-1:0] ld_addr,
  input  logic [31:0]         ld_data,
  output logic                busy
);

  localparam int BA_W = FLASH_AW + 2;

  // SS_IDX only documents which select bit the wrapper routed here; it must be non-negative.
  if (SS_IDX < 0) begin : g_ss_idx_invalid
  end

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [22:0]       shift_q, shift_d;
  logic [BA_W-1:0]   byte_addr_q, byte_addr_d;
  logic [7:0]        data_q, data_d;
  logic              miso_q, miso_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  logic              rise, fall, ss_fall;
  logic [7:0]        opcode;
  logic [7:0]        rd_byte;

  spi_flash_mem #(.FLASH_AW(FLASH_AW)) u_mem (
    .clock        (clock),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .rd_byte_addr (byte_addr_q),
    .rd_byte      (rd_byte)
  );

  always_comb begin
    rise        = spi_sck & ~sck_q;
    fall        = ~spi_sck & sck_q;
    ss_fall     = ss_q & ~spi_ss;
    opcode      = {shift_q[6:0], spi_mosi};
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    byte_addr_d = byte_addr_q;
    data_d      = data_q;
    miso_d      = miso_q;
    sck_d       = spi_sck;
    ss_d        = spi_ss;
`ifdef SPI_FLASH_FAST_READ_EN
    fast_d      = fast_q;
`endif

    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (ss_fall) begin
        state_d = CMD;
        cnt_d   = '0;
        shift_d = '0;
`ifdef SPI_FLASH_FAST_READ_EN
        fast_d  = 1'b0;
`endif
      end
    end else if (spi_ss) begin
      // Deselect aborts whatever partial command, address or byte was in flight.
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CMD: if (rise) begin
          shift_d = {shift_q[21:0], spi_mosi};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(CMD_BITS - 1)) begin
            cnt_d = '0;
            if (opcode == CMD_READ) begin
              state_d = ADDR;
            end
`ifdef SPI_FLASH_FAST_READ_EN
            else if (opcode == CMD_FAST_READ) begin
              state_d = ADDR;
              fast_d  = 1'b1;
            end
`endif
            else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          shift_d = {shift_q[21:0], spi_mosi};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_BITS - 1)) begin
            cnt_d       = '0;
            byte_addr_d = BA_W'({shift_q, spi_mosi});
`ifdef SPI_FLASH_FAST_READ_EN
            state_d     = fast_q ? DUMMY : DATA;
`else
            state_d     = DATA;
`endif
          end
        end
        DUMMY: if (rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DUMMY_BITS - 1)) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: if (fall) begin
          // The array is sampled only at the first bit of each byte, so preloads land on the next byte.
          if (cnt_q == 5'd0) begin
            miso_d = rd_byte[7];
            data_d = {rd_byte[6:0], 1'b0};
          end else begin
            miso_d = data_q[7];
            data_d = {data_q[6:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d       = '0;
            byte_addr_d = byte_addr_q + 1'b1;
          end
        end
        IGNORE: miso_d = 1'b0;
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_addr_q <= '0;
      data_q      <= '0;
      miso_q      <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      byte_addr_q <= byte_addr_d;
      data_q      <= data_d;
      miso_q      <= miso_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  assign spi_miso = miso_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_model.sv
// Self-checking bench for spi_flash_model: SPI master tasks plus a word-array reference model.
module tb_spi_flash_model;

  localparam int FLASH_AW = 22;
  localparam int unsigned CAP_MASK = (32'd1 << (FLASH_AW + 2)) - 1;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                spi_sck = 1'b0;
  logic                spi_ss = 1'b1;
  logic                spi_mosi = 1'b0;
  logic                spi_miso;
  logic                ld_valid = 1'b0;
  logic [FLASH_AW-1:0] ld_addr = '0;
  logic [31:0]         ld_data = '0;
  logic                busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] wmodel [int unsigned];
  logic [7:0]  rx_q [$];
  logic        busy_all;
  logic        end_busy;

  spi_flash_model #(.FLASH_AW(FLASH_AW), .SS_IDX(0)) dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Reference: byte a lives in word a/4 at lane a%4, addresses wrap at capacity.
  function automatic logic [7:0] model_byte(input int unsigned a);
    int unsigned m;
    logic [31:0] w;
    m = a & CAP_MASK;
    w = wmodel[m >> 2];
    return w[(m % 4) * 8 +: 8];
  endfunction

  task automatic preload(input int unsigned wa, input logic [31:0] d);
    @(negedge clock);
    ld_valid = 1'b1;
    ld_addr  = wa[FLASH_AW-1:0];
    ld_data  = d;
    @(negedge clock);
    ld_valid = 1'b0;
    wmodel[wa] = d;
  endtask

  // One mode-0 bit: sck low with mosi set, then miso sampled just as sck rises.
  task automatic spi_bit(input logic b, output logic m, output logic bz);
    spi_sck  = 1'b0;
    spi_mosi = b;
    repeat (2) @(negedge clock);
    m  = spi_miso;
    bz = busy;
    spi_sck = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
    logic m, bz;
    logic [7:0] b;
    rx_q.delete();
    busy_all = 1'b1;
    spi_ss = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 7; i >= 0; i--) begin spi_bit(op[i], m, bz); busy_all &= bz; end
    for (int i = 23; i >= 0; i--) begin spi_bit(addr[i], m, bz); busy_all &= bz; end
    if (op == 8'h0B) begin
      for (int i = 0; i < 8; i++) begin spi_bit(1'b0, m, bz); busy_all &= bz; end
    end
    for (int k = 0; k < nbytes; k++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        spi_bit(1'b0, m, bz);
        busy_all &= bz;
        b = {b[6:0], m};
      end
      rx_q.push_back(b);
    end
    spi_sck = 1'b0;
    repeat (2) @(negedge clock);
    spi_ss = 1'b1;
    @(negedge clock);
    end_busy = busy;
    repeat (2) @(negedge clock);
    $display("frame op=%02h addr=%06h bytes=%p", op, addr, rx_q);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (spi_miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: miso=%b busy=%b expected 0/0", spi_miso, busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (spi_miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: miso=%b busy=%b expected 0/0", spi_miso, busy);
    end
  endtask

  task automatic test_read_basic();
    preload(0, 32'h44332211);
    run_frame(8'h03, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== model_byte(i)) begin
        errors++;
        $display("FAIL read_basic byte%0d: got %02h expected %02h", i, rx_q[i], model_byte(i));
      end
    end
    checks++;
    if (busy_all !== 1'b1) begin errors++; $display("FAIL read_basic busy_during: got %b expected 1", busy_all); end
    checks++;
    if (end_busy !== 1'b0) begin errors++; $display("FAIL read_basic busy_after: got %b expected 0", end_busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    preload((1 << FLASH_AW) - 1, 32'hDDCCBBAA);
    exp_b[0] = 8'hCC; exp_b[1] = 8'hDD; exp_b[2] = 8'h11; exp_b[3] = 8'h22;
    run_frame(8'h03, 24'hFFFFFE, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL wrap byte%0d: got %02h expected %02h", i, rx_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_ignore();
    run_frame(8'h9F, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== 8'h00) begin errors++; $display("FAIL ignore byte%0d: got %02h expected 00", i, rx_q[i]); end
    end
    checks++;
    if (busy_all !== 1'b1) begin errors++; $display("FAIL ignore busy: got %b expected 1", busy_all); end
    run_frame(8'h03, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== model_byte(i)) begin
        errors++;
        $display("FAIL after_ignore byte%0d: got %02h expected %02h", i, rx_q[i], model_byte(i));
      end
    end
  endtask

  task automatic test_abort();
    logic m, bz;
    logic [31:0] partial;
    partial = {8'h03, 24'hABCDEF};
    spi_ss = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 31; i >= 4; i--) spi_bit(partial[i], m, bz);
    spi_sck = 1'b0;
    repeat (2) @(negedge clock);
    spi_ss = 1'b1;
    repeat (3) @(negedge clock);
    preload(1, 32'h88776655);
    run_frame(8'h03, 24'h000004, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== model_byte(4 + i)) begin
        errors++;
        $display("FAIL abort byte%0d: got %02h expected %02h", i, rx_q[i], model_byte(4 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic m, bz, any_m, any_b;
    logic [31:0] hdr;
    hdr = {8'h03, 24'h000008};
    preload(2, 32'hFFFFFFFF);
    spi_ss = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 31; i >= 0; i--) spi_bit(hdr[i], m, bz);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m, bz);
    checks++;
    if (m !== 1'b1 || bz !== 1'b1) begin errors++; $display("FAIL reset_mid pre: miso=%b busy=%b expected 1/1", m, bz); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (spi_miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: miso=%b busy=%b expected 0/0", spi_miso, busy);
    end
    @(negedge clock);
    spi_sck = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    any_m = 1'b0;
    any_b = 1'b0;
    for (int i = 31; i >= 0; i--) begin spi_bit(hdr[i], m, bz); any_m |= m; any_b |= bz; end
    for (int i = 0; i < 16; i++) begin spi_bit(1'b0, m, bz); any_m |= m; any_b |= bz; end
    checks++;
    if (any_m !== 1'b0) begin errors++; $display("FAIL reset_mid ss_low_miso: got %b expected 0", any_m); end
    checks++;
    if (any_b !== 1'b0) begin errors++; $display("FAIL reset_mid ss_low_busy: got %b expected 0", any_b); end
    spi_sck = 1'b0;
    repeat (2) @(negedge clock);
    spi_ss = 1'b1;
    repeat (3) @(negedge clock);
    run_frame(8'h03, 24'h000008, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== model_byte(8 + i)) begin
        errors++;
        $display("FAIL reset_mid reread byte%0d: got %02h expected %02h", i, rx_q[i], model_byte(8 + i));
      end
    end
  endtask

  task automatic test_fast_read();
    logic [7:0] exp_b;
    run_frame(8'h0B, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef SPI_FLASH_FAST_READ_EN
      exp_b = model_byte(i);
`else
      exp_b = 8'h00;
`endif
      checks++;
      if (rx_q[i] !== exp_b) begin
        errors++;
        $display("FAIL fast_read byte%0d: got %02h expected %02h", i, rx_q[i], exp_b);
      end
    end
  endtask

  task automatic test_random();
    int unsigned w, off, n, a;
    for (int it = 0; it < 16; it++) begin
      w = $urandom & ((1 << FLASH_AW) - 1);
      for (int k = 0; k < 3; k++) preload((w + k) & ((1 << FLASH_AW) - 1), $urandom);
      off = $urandom_range(0, 3);
      n   = $urandom_range(1, 6);
      a   = (w * 4 + off) & CAP_MASK;
      run_frame(8'h03, a[23:0], n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_q[i] !== model_byte(a + i)) begin
          errors++;
          $display("FAIL random it%0d byte%0d: got %02h expected %02h", it, i, rx_q[i], model_byte(a + i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_wrap();
    test_ignore();
    test_abort();
    test_reset_mid();
    test_fast_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_model.md
Name: spi_flash_model

Overview:
Clock-synchronous SPI NOR flash slave. It sits directly downstream of the APB SPI master / XIP bridge and consumes spi_sck, spi_ss and spi_mosi. It answers READ (0x03) frames from an internal byte-addressable array on spi_miso. The array is preloaded through a simple word-write port, so simulation and FPGA benches can boot XIP code from it.

Parameters:
FLASH_AW, 22, word-address width; capacity = 4*2^FLASH_AW bytes (16 MiB default).
SS_IDX, 0, bit of the incoming select vector this model responds to (selection done by instantiating wrapper; model sees 1 bit).

Ports:
clock  in  1  system clock; spi_* inputs are launched from registers on this clock.
reset  in  1  asynchronous, active-high.
spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
spi_ss  in  1  chip select, active low.
spi_mosi  in  1  master-out data, MSB first.
spi_miso  out  1  slave-out data, MSB first.
ld_valid  in  1  preload write strobe, one word per cycle.
ld_addr  in  FLASH_AW  preload word address.
ld_data  in  32  preload word; byte lane 0 = bits[7:0] = lowest byte address.
busy  out  1  high while a frame is active (state != IDLE).

Behaviour:
- Reset values:
  - state=IDLE, spi_miso=0, busy=0, bit counter=0, shift register=0, sck_q=0.
  - Array contents are not reset.
- Edge detection:
  - sck_q registers spi_sck.
  - rise = spi_sck & ~sck_q; fall = ~spi_sck & sck_q (combinational, same cycle).
  - sck high and low phases are >= 2 clock cycles each; the bridge with divider 1 meets this.
- Sampling and driving:
  - spi_mosi is sampled on the clock where rise=1.
  - spi_miso is updated on the clock where fall=1, so it is valid 1 cycle after sck falls, before the next rise.
- Frame start: a falling edge of spi_ss (ss 1->0) in IDLE -> CMD, bit counter cleared.
- States:
  - IDLE: miso=0; ignore sck.
  - CMD: shift 8 bits on rises. After the 8th: opcode 0x03 -> ADDR; any other opcode -> IGNORE.
  - ADDR: shift 24 bits. After the 24th rise, byte_addr = shifted value modulo capacity (upper bits dropped); -> DATA.
  - DATA:
    - cur_byte = array byte at byte_addr (async read); its MSB is driven on the next fall.
    - Each fall drives the next bit. After 8 bits, byte_addr increments (wraps at capacity) and the next byte loads.
    - Streaming continues indefinitely while ss is low.
  - IGNORE: miso held 0 until ss deasserts.
- ss deassert (1) in any non-IDLE state:
  - -> IDLE on the next clock; miso=0.
  - A partial byte or partial address is discarded.
- ss low at reset release: stay IDLE; a frame starts only on a 1->0 transition.
- Preload:
  - ld_valid writes ld_data to word ld_addr on that clock.
  - This is allowed at any time. If it targets the byte currently being shifted, the new value is used only from the next byte load.
- Byte order: byte address a -> word a[FLASH_AW+1:2], lane a[1:0]. A 32-bit XIP read at 0x30000000 therefore returns bytes a, a+1, a+2, a+3 in frame order.
- Bridge frame: 64 sck cycles = 8 cmd + 24 addr + 32 data bits; rx bits[31:0] hold four bytes.

Optional Feature:
SPI_FLASH_FAST_READ_EN:
- Defined: opcode 0x0B is also accepted. ADDR is followed by a DUMMY state of 8 rises with miso=0, then DATA identical to 0x03.
- Undefined: 0x0B goes to IGNORE like any unknown opcode.

Decomposition:
- Package spi_flash_pkg:
  - opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B;
  - state encoding IDLE/CMD/ADDR/DUMMY/DATA/IGNORE (3 bits);
  - CMD_BITS=8, ADDR_BITS=24, DUMMY_BITS=8.
- One sub-module, spi_flash_mem: 2^FLASH_AW x 32 array, synchronous write port (ld_*), async byte read by byte address.

Test Plan:
- Preload word0=0x44332211; frame 0x03,0x000000, 32 data clocks -> miso bytes 0x11,0x22,0x33,0x44; busy high throughout, low 1 cycle after ss rises.
- Preload last word=0xDDCCBBAA; read 0x03 at byte 0xFFFFFE for 4 bytes -> 0xCC,0xDD then wrap to word0 bytes 0x11,0x22.
- Opcode 0x9F followed by 32 clocks -> miso constant 0, state IGNORE; new 0x03 frame after ss toggle reads correctly.
- ss deasserted after 20 address bits, then a fresh frame at 0x000004 with word1=0x88776655 -> 0x55,0x66,0x77,0x88 (no leftover bits).
- Reset asserted mid-DATA -> miso=0, busy=0 immediately; after release with ss still low, no response until ss 1->0.
- With SPI_FLASH_FAST_READ_EN: 0x0B,0x000000, 8 dummy clocks -> 0x11,0x22,0x33,0x44; without it -> all zeros.
